// File: rtl/pcie_pipe_rx_aligner_pkg.sv
// Shared symbol codes, FSM encodings and small helpers for the PIPE RX aligner slice.
package pcie_pipe_rx_aligner_pkg;

   localparam logic [7:0] COM_SYM = 8'hBC;

   localparam logic [1:0] HUNT   = 2'd0;
   localparam logic [1:0] CHECK  = 2'd1;
   localparam logic [1:0] LOCKED = 2'd2;

   typedef struct packed {
      logic [3:0] good;
      logic [3:0] miss;
   } lockCnt_t;

   // Narrow datapaths still get a one-bit Offset so the port never collapses to zero width.
   function automatic int calcOffsetWidth(input int dataWidth);
      return (dataWidth <= 16) ? 1 : $clog2(dataWidth / 8);
   endfunction

   function automatic logic [3:0] satInc4(input logic [3:0] value);
      return (value == 4'hF) ? value : value + 4'd1;
   endfunction

endpackage

// File: rtl/pcie_pipe_byte_rotator.sv
// Combinational byte rotator: selects Bytes consecutive bytes of a two-word window starting at i_offset.
module pcie_pipe_byte_rotator #(
   parameter int Bytes = 4,
   parameter int OW    = 2
) (
   input  logic [16*Bytes-1:0] i_catData,
   input  logic [2*Bytes-1:0]  i_catK,
   input  logic [OW-1:0]       i_offset,
   output logic [8*Bytes-1:0]  o_data,
   output logic [Bytes-1:0]    o_k
);

   logic [OW+2:0] w_bitOffset;

   assign w_bitOffset = {i_offset, 3'b000};
   assign o_data      = i_catData[w_bitOffset +: 8*Bytes];
   assign o_k         = i_catK[i_offset +: Bytes];

endmodule

// File: rtl/pcie_pipe_rx_aligner.sv
// PIPE RX symbol aligner: finds the COM lane, rotates each word so COM lands in lane 0,
// and qualifies the aligned stream with a hunt/check/locked symbol-lock FSM.
module pcie_pipe_rx_aligner
   import pcie_pipe_rx_aligner_pkg::*;
#(
   parameter  int DataWidth   = 32,
   parameter  int LockCount   = 4,
   parameter  int UnlockCount = 4,
   localparam int B           = DataWidth / 8,
   localparam int OW          = calcOffsetWidth(DataWidth)
) (
   input  logic                 pclk,
   input  logic                 nreset,
   input  logic [DataWidth-1:0] RxDataIn,
   input  logic [B-1:0]         RxDataKIn,
   input  logic                 RxValidIn,
   output logic [DataWidth-1:0] RxData,
   output logic [B-1:0]         RxDataK,
   output logic                 RxValid,
   output logic                 Locked,
   output logic [OW-1:0]        Offset
);

   logic [DataWidth-1:0]   r_holdData;
   logic [B-1:0]           r_holdK;
   logic [DataWidth-1:0]   r_rxData;
   logic [B-1:0]           r_rxK;
   logic                   r_rxValid;
   logic [1:0]             r_state;
   logic [OW-1:0]          r_offset;
   lockCnt_t               r_cnt;

   logic [2*DataWidth-1:0] w_catData;
   logic [2*B-1:0]         w_catK;
   logic [DataWidth-1:0]   w_rotData;
   logic [B-1:0]           w_rotK;
   logic                   w_comFound;
   logic [OW-1:0]          w_comLane;
   logic                   w_laneMatch;
   logic [3:0]             w_goodInc;
   logic [3:0]             w_missInc;
   logic [1:0]             w_stateNext;
   logic [OW-1:0]          w_offsetNext;
   lockCnt_t               w_cntNext;

   assign w_catData = {RxDataIn, r_holdData};
   assign w_catK    = {RxDataKIn, r_holdK};

   pcie_pipe_byte_rotator #(
      .Bytes (B),
      .OW    (OW)
   ) u_rotator (
      .i_catData (w_catData),
      .i_catK    (w_catK),
      .i_offset  (r_offset),
      .o_data    (w_rotData),
      .o_k       (w_rotK)
   );

   // Scan from the top lane down so the lowest COM lane wins.
   always_comb begin
      w_comFound = 1'b0;
      w_comLane  = '0;
      for (int i = B - 1; i >= 0; i--) begin
         if (RxDataKIn[i] && (RxDataIn[8*i +: 8] == COM_SYM)) begin
            w_comFound = 1'b1;
            w_comLane  = OW'(i);
         end
      end
   end

   assign w_laneMatch = (w_comLane == r_offset);
   assign w_goodInc   = satInc4(r_cnt.good);
   assign w_missInc   = satInc4(r_cnt.miss);

   always_comb begin
      w_stateNext  = r_state;
      w_offsetNext = r_offset;
      w_cntNext    = r_cnt;
      if (RxValidIn && w_comFound) begin
         case (r_state)
            HUNT: begin
               w_offsetNext   = w_comLane;
               w_cntNext.good = 4'd1;
               if (LockCount <= 1) begin
                  w_stateNext    = LOCKED;
                  w_cntNext.miss = 4'd0;
               end else begin
                  w_stateNext = CHECK;
               end
            end
            CHECK: begin
               if (w_laneMatch) begin
                  w_cntNext.good = w_goodInc;
                  if (w_goodInc >= 4'(LockCount)) begin
                     w_stateNext    = LOCKED;
                     w_cntNext.miss = 4'd0;
                  end
               end else begin
                  w_offsetNext   = w_comLane;
                  w_cntNext.good = 4'd1;
               end
            end
            LOCKED: begin
               // Offset is frozen here; only the miss counter reacts to a wrong lane.
               if (w_laneMatch) begin
                  w_cntNext.miss = 4'd0;
               end else begin
                  w_cntNext.miss = w_missInc;
                  if (w_missInc >= 4'(UnlockCount)) begin
                     w_stateNext = HUNT;
                  end
               end
            end
            default: begin
               w_stateNext = HUNT;
            end
         endcase
      end
   end

   // Invalid PHY words freeze the whole pipeline; only the valid flag drops.
   always_ff @(posedge pclk or negedge nreset) begin
      if (!nreset) begin
         r_holdData <= '0;
         r_holdK    <= '0;
         r_rxData   <= '0;
         r_rxK      <= '0;
         r_rxValid  <= 1'b0;
         r_state    <= HUNT;
         r_offset   <= '0;
         r_cnt      <= '0;
      end else begin
         r_rxValid <= RxValidIn && (w_stateNext == LOCKED);
         if (RxValidIn) begin
            r_holdData <= RxDataIn;
            r_holdK    <= RxDataKIn;
            r_rxData   <= w_rotData;
            r_rxK      <= w_rotK;
            r_state    <= w_stateNext;
            r_offset   <= w_offsetNext;
            r_cnt      <= w_cntNext;
         end
      end
   end

   assign RxData  = r_rxData;
   assign RxDataK = r_rxK;
   assign RxValid = r_rxValid;
   assign Locked  = (r_state == LOCKED);
   assign Offset  = r_offset;

endmodule

// File: tb/tb_pcie_pipe_rx_aligner.sv
// Directed bench for the PIPE RX aligner at 32, 8 and 64 bit data widths sharing one stimulus bus.
module tb_pcie_pipe_rx_aligner;

   logic        clk;
   logic        nreset;
   logic [63:0] dataIn;
   logic [7:0]  kIn;
   logic        validIn;

   logic [31:0] rxData32;
   logic [3:0]  rxK32;
   logic        rxValid32, locked32;
   logic [1:0]  offset32;

   logic [7:0]  rxData8;
   logic [0:0]  rxK8;
   logic        rxValid8, locked8;
   logic [0:0]  offset8;

   logic [63:0] rxData64;
   logic [7:0]  rxK64;
   logic        rxValid64, locked64;
   logic [2:0]  offset64;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  k;
      logic        valid;
      logic [31:0] expData;
      logic [3:0]  expK;
      logic        expValid;
      logic        expLocked;
      logic [1:0]  expOffset;
   } vec_t;

   vec_t vecs[14];

   pcie_pipe_rx_aligner #(.DataWidth(32), .LockCount(4), .UnlockCount(4)) u_dut32 (
      .pclk      (clk),
      .nreset    (nreset),
      .RxDataIn  (dataIn[31:0]),
      .RxDataKIn (kIn[3:0]),
      .RxValidIn (validIn),
      .RxData    (rxData32),
      .RxDataK   (rxK32),
      .RxValid   (rxValid32),
      .Locked    (locked32),
      .Offset    (offset32)
   );

   pcie_pipe_rx_aligner #(.DataWidth(8), .LockCount(4), .UnlockCount(4)) u_dut8 (
      .pclk      (clk),
      .nreset    (nreset),
      .RxDataIn  (dataIn[7:0]),
      .RxDataKIn (kIn[0:0]),
      .RxValidIn (validIn),
      .RxData    (rxData8),
      .RxDataK   (rxK8),
      .RxValid   (rxValid8),
      .Locked    (locked8),
      .Offset    (offset8)
   );

   pcie_pipe_rx_aligner #(.DataWidth(64), .LockCount(4), .UnlockCount(4)) u_dut64 (
      .pclk      (clk),
      .nreset    (nreset),
      .RxDataIn  (dataIn),
      .RxDataKIn (kIn),
      .RxValidIn (validIn),
      .RxData    (rxData64),
      .RxDataK   (rxK64),
      .RxValid   (rxValid64),
      .Locked    (locked64),
      .Offset    (offset64)
   );

   always #5 clk = ~clk;

   // Byte j of word w is w*bytes+j, except the COM lane which carries 8'hBC.
   function automatic logic [63:0] mkWord(input int w, input int lane, input int bytes);
      logic [63:0] word = '0;
      for (int j = 0; j < bytes; j++)
         word[8*j +: 8] = (j == lane) ? 8'hBC : 8'(w * bytes + j);
      return word;
   endfunction

   function automatic logic [7:0] mkK(input int lane);
      return (lane < 0) ? 8'h00 : 8'(1 << lane);
   endfunction

   function automatic logic [31:0] w32(input int w, input int lane);
      return 32'(mkWord(w, lane, 4));
   endfunction

   function automatic logic [7:0] streamByte(input int n);
      return (n % 4 == 0) ? 8'hBC : 8'(n);
   endfunction

   task automatic applyStimulus(input logic [63:0] d, input logic [7:0] k, input logic v);
      dataIn  = d;
      kIn     = k;
      validIn = v;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
      end
   endtask

   task automatic pulseReset();
      @(negedge clk);
      nreset  = 1'b0;
      validIn = 1'b0;
      dataIn  = '0;
      kIn     = '0;
      @(posedge clk);
      #1;
      @(negedge clk);
      nreset = 1'b1;
   endtask

   initial begin
      clk     = 1'b0;
      nreset  = 1'b0;
      dataIn  = '0;
      kIn     = '0;
      validIn = 1'b0;

      vecs[0]  = '{w32(0, 2),  4'b0100, 1'b1, 32'h00000000, 4'h0, 1'b0, 1'b0, 2'd2};
      vecs[1]  = '{w32(1, 2),  4'b0100, 1'b1, 32'h050403BC, 4'h1, 1'b0, 1'b0, 2'd2};
      vecs[2]  = '{w32(2, 2),  4'b0100, 1'b1, 32'h090807BC, 4'h1, 1'b0, 1'b0, 2'd2};
      vecs[3]  = '{w32(3, 2),  4'b0100, 1'b1, 32'h0D0C0BBC, 4'h1, 1'b1, 1'b1, 2'd2};
      vecs[4]  = '{w32(4, 2),  4'b0100, 1'b1, 32'h11100FBC, 4'h1, 1'b1, 1'b1, 2'd2};
      vecs[5]  = '{w32(5, 2),  4'b0100, 1'b1, 32'h151413BC, 4'h1, 1'b1, 1'b1, 2'd2};
      vecs[6]  = '{w32(6, 2),  4'b0100, 1'b1, 32'h191817BC, 4'h1, 1'b1, 1'b1, 2'd2};
      vecs[7]  = '{w32(7, 2),  4'b0100, 1'b1, 32'h1D1C1BBC, 4'h1, 1'b1, 1'b1, 2'd2};
      vecs[8]  = '{w32(8, 2),  4'b0100, 1'b1, 32'h21201FBC, 4'h1, 1'b1, 1'b1, 2'd2};
      vecs[9]  = '{w32(40, 0), 4'b0001, 1'b0, 32'h21201FBC, 4'h1, 1'b0, 1'b1, 2'd2};
      vecs[10] = '{w32(41, 0), 4'b0001, 1'b0, 32'h21201FBC, 4'h1, 1'b0, 1'b1, 2'd2};
      vecs[11] = '{w32(42, 0), 4'b0001, 1'b0, 32'h21201FBC, 4'h1, 1'b0, 1'b1, 2'd2};
      vecs[12] = '{w32(9, 2),  4'b0100, 1'b1, 32'h252423BC, 4'h1, 1'b1, 1'b1, 2'd2};
      vecs[13] = '{w32(10, 2), 4'b0100, 1'b1, 32'h292827BC, 4'h1, 1'b1, 1'b1, 2'd2};

      #1;
      checkOutput("reset rxData32", rxData32, 32'h0);
      checkOutput("reset rxK32", rxK32, 4'h0);
      checkOutput("reset rxValid32", rxValid32, 1'b0);
      checkOutput("reset locked32", locked32, 1'b0);
      checkOutput("reset offset32", offset32, 2'd0);
      checkOutput("reset rxData64", rxData64, 64'h0);
      checkOutput("reset locked8", locked8, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      nreset = 1'b1;

      $display("[TB] 32-bit lock, gap and resume table");
      for (int i = 0; i < 14; i++) begin
         applyStimulus({32'h0, vecs[i].data}, {4'h0, vecs[i].k}, vecs[i].valid);
         checkOutput($sformatf("t1 row%0d rxData", i), rxData32, vecs[i].expData);
         checkOutput($sformatf("t1 row%0d rxK", i), rxK32, vecs[i].expK);
         checkOutput($sformatf("t1 row%0d rxValid", i), rxValid32, vecs[i].expValid);
         checkOutput($sformatf("t1 row%0d locked", i), locked32, vecs[i].expLocked);
         checkOutput($sformatf("t1 row%0d offset", i), offset32, vecs[i].expOffset);
      end

      $display("[TB] asynchronous reset while locked");
      nreset = 1'b0;
      #1;
      checkOutput("t6 async rxData", rxData32, 32'h0);
      checkOutput("t6 async rxK", rxK32, 4'h0);
      checkOutput("t6 async rxValid", rxValid32, 1'b0);
      checkOutput("t6 async locked", locked32, 1'b0);
      checkOutput("t6 async offset", offset32, 2'd0);
      dataIn  = mkWord(11, 2, 4);
      kIn     = 8'h04;
      validIn = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("t6 held rxData", rxData32, 32'h0);
      checkOutput("t6 held offset", offset32, 2'd0);
      @(negedge clk);
      nreset = 1'b1;
      for (int w = 0; w < 4; w++) begin
         applyStimulus(mkWord(w, 2, 4), 8'h04, 1'b1);
         checkOutput($sformatf("t6 w%0d offset", w), offset32, 2'd2);
         checkOutput($sformatf("t6 w%0d locked", w), locked32, w == 3);
         checkOutput($sformatf("t6 w%0d rxValid", w), rxValid32, w == 3);
         if (w == 0) checkOutput("t6 w0 rxData", rxData32, 32'h0);
         if (w == 3) checkOutput("t6 w3 rxData", rxData32, 32'h0D0C0BBC);
      end

      $display("[TB] 32-bit lane shift, unlock and relock");
      for (int w = 4; w <= 11; w++) begin
         applyStimulus(mkWord(w, 1, 4), 8'h02, 1'b1);
         checkOutput($sformatf("t2 w%0d locked", w), locked32, (w <= 6) || (w == 11));
         checkOutput($sformatf("t2 w%0d rxValid", w), rxValid32, (w <= 6) || (w == 11));
         checkOutput($sformatf("t2 w%0d offset", w), offset32, (w <= 7) ? 2'd2 : 2'd1);
      end
      checkOutput("t2 relock rxData", rxData32, 32'h2C2B2ABC);
      checkOutput("t2 relock rxK", rxK32, 4'b0001);

      $display("[TB] 32-bit double COM in hunt, then lane change during check");
      pulseReset();
      applyStimulus(64'hBC52BC50, 8'b1010, 1'b1);
      checkOutput("t5 offset", offset32, 2'd1);
      checkOutput("t5 locked", locked32, 1'b0);
      applyStimulus(mkWord(20, 3, 4), mkK(3), 1'b1);
      checkOutput("t5 rotated rxData", rxData32, 32'h50BC52BC);
      checkOutput("t5 rotated rxK", rxK32, 4'b0101);
      checkOutput("t3 move offset", offset32, 2'd3);
      applyStimulus(mkWord(30, -1, 4), mkK(-1), 1'b1);
      checkOutput("t3 nocom offset", offset32, 2'd3);
      checkOutput("t3 nocom locked", locked32, 1'b0);
      applyStimulus(mkWord(21, 3, 4), mkK(3), 1'b1);
      checkOutput("t3 good2 offset", offset32, 2'd3);
      applyStimulus(mkWord(22, 0, 4), mkK(0), 1'b1);
      checkOutput("t3 lane0 offset", offset32, 2'd0);
      checkOutput("t3 lane0 locked", locked32, 1'b0);
      applyStimulus(mkWord(23, 0, 4), mkK(0), 1'b1);
      checkOutput("t3 c2 locked", locked32, 1'b0);
      checkOutput("t3 c2 rxData", rxData32, 32'h5B5A59BC);
      checkOutput("t3 c2 rxK", rxK32, 4'b0001);
      applyStimulus(mkWord(24, 0, 4), mkK(0), 1'b1);
      checkOutput("t3 c3 locked", locked32, 1'b0);
      applyStimulus(mkWord(25, 0, 4), mkK(0), 1'b1);
      checkOutput("t3 c4 locked", locked32, 1'b1);
      checkOutput("t3 c4 rxValid", rxValid32, 1'b1);
      checkOutput("t3 c4 offset", offset32, 2'd0);

      $display("[TB] 8-bit lock and gap");
      pulseReset();
      for (int n = 0; n < 16; n++) begin
         applyStimulus({56'h0, streamByte(n)}, {7'h0, n % 4 == 0}, 1'b1);
         checkOutput($sformatf("w8 n%0d offset", n), offset8, 1'b0);
         checkOutput($sformatf("w8 n%0d locked", n), locked8, n >= 12);
         checkOutput($sformatf("w8 n%0d rxValid", n), rxValid8, n >= 12);
         if (n >= 1) begin
            checkOutput($sformatf("w8 n%0d rxData", n), rxData8, streamByte(n - 1));
            checkOutput($sformatf("w8 n%0d rxK", n), rxK8, (n - 1) % 4 == 0);
         end
      end
      for (int g = 0; g < 3; g++) begin
         applyStimulus(64'hBC, 8'h01, 1'b0);
         checkOutput($sformatf("w8 gap%0d rxValid", g), rxValid8, 1'b0);
         checkOutput($sformatf("w8 gap%0d rxData", g), rxData8, 8'h0E);
         checkOutput($sformatf("w8 gap%0d locked", g), locked8, 1'b1);
      end
      for (int n = 16; n < 18; n++) begin
         applyStimulus({56'h0, streamByte(n)}, {7'h0, n % 4 == 0}, 1'b1);
         checkOutput($sformatf("w8 n%0d rxValid", n), rxValid8, 1'b1);
         checkOutput($sformatf("w8 n%0d rxData", n), rxData8, streamByte(n - 1));
         checkOutput($sformatf("w8 n%0d offset", n), offset8, 1'b0);
      end

      $display("[TB] 64-bit lock and gap");
      pulseReset();
      for (int w = 0; w < 6; w++) begin
         applyStimulus(mkWord(w, 5, 8), mkK(5), 1'b1);
         checkOutput($sformatf("w64 w%0d offset", w), offset64, 3'd5);
         checkOutput($sformatf("w64 w%0d locked", w), locked64, w >= 3);
         checkOutput($sformatf("w64 w%0d rxValid", w), rxValid64, w >= 3);
         if (w >= 1) begin
            checkOutput($sformatf("w64 w%0d com", w), rxData64[7:0], 8'hBC);
            checkOutput($sformatf("w64 w%0d rxK", w), rxK64, 8'h01);
         end
         if (w == 1) checkOutput("w64 w1 rxData", rxData64, 64'h0C0B0A09080706BC);
         if (w == 3) checkOutput("w64 w3 rxData", rxData64, 64'h1C1B1A19181716BC);
      end
      for (int g = 0; g < 3; g++) begin
         applyStimulus(mkWord(50, 0, 8), mkK(0), 1'b0);
         checkOutput($sformatf("w64 gap%0d rxValid", g), rxValid64, 1'b0);
         checkOutput($sformatf("w64 gap%0d rxData", g), rxData64, 64'h2C2B2A29282726BC);
         checkOutput($sformatf("w64 gap%0d locked", g), locked64, 1'b1);
      end
      applyStimulus(mkWord(6, 5, 8), mkK(5), 1'b1);
      checkOutput("w64 resume rxValid", rxValid64, 1'b1);
      checkOutput("w64 resume rxData", rxData64, 64'h34333231302F2EBC);
      checkOutput("w64 resume offset", offset64, 3'd5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
